mod_cascade_counter: RTL and testbench

//  Parametrised, cascadable modulo counter stage for the real-time clock chain (seconds/minutes/hours).

---
 rtl/rtc_pkg.sv | 23 ++
 rtl/bin2bcd_99.sv | 24 ++
 rtl/mod_cascade_counter.sv | 127 ++++++++++++
 tb/tb_mod_cascade_counter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and helpers for the real-time clock counter chain.
package rtc_pkg;

    localparam int unsigned SEC_MAX    = 59;
    localparam int unsigned MIN_MAX    = 59;
    localparam int unsigned HOUR24_MAX = 23;
    localparam int unsigned HOUR12_MIN = 1;
    localparam int unsigned HOUR12_MAX = 12;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned BCD_LIMIT  = 99;

    function automatic logic is_in_range(input int unsigned value,
                                         input int unsigned lo,
                                         input int unsigned hi);
        return (value >= lo) && (value <= hi);
    endfunction

    // Constant-only conversion, used to build the reset image of the BCD register.
    function automatic logic [7:0] bcd_of(input int unsigned value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

endpackage

// File: rtl/bin2bcd_99.sv
// Combinational 7-bit binary to two-digit BCD converter for inputs 0..99.
module bin2bcd_99 (
    input  logic [6:0] bin,
    output logic [7:0] bcd
);

    logic [3:0] tens;
    logic [3:0] units;

    // Largest multiple of ten not exceeding bin selects the tens digit.
    always_comb begin
        tens  = 4'd0;
        units = bin[3:0];
        for (int i = 1; i <= 9; i++) begin
            if (bin >= 7'(10 * i)) begin
                tens  = 4'(i);
                units = 4'(bin - 7'(10 * i));
            end
        end
    end

    assign bcd = {tens, units};

endmodule

// File: rtl/mod_cascade_counter.sv
// Cascadable modulo counter stage (MIN_VALUE..MAX_VALUE) with load, carry-free adjust,
// combinational carry-out and a registered BCD copy of the count.
module mod_cascade_counter
    import rtc_pkg::*;
#(
    parameter int unsigned WIDTH       = CNT_W,
    parameter int unsigned MIN_VALUE   = 0,
    parameter int unsigned MAX_VALUE   = SEC_MAX,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_in,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             adj_inc,
    input  logic             adj_dec,
    output logic [WIDTH-1:0] q,
    output logic [7:0]       q_bcd,
    output logic             tc_out,
    output logic             wrap_pulse,
    output logic             load_err
);

    if (MAX_VALUE > BCD_LIMIT) begin : g_chk_bcd
        $error("MAX_VALUE must not exceed 99");
    end
    if (MAX_VALUE >= 2 ** WIDTH) begin : g_chk_width
        $error("WIDTH too small to hold MAX_VALUE");
    end
    if (MIN_VALUE > MAX_VALUE) begin : g_chk_order
        $error("MIN_VALUE must not exceed MAX_VALUE");
    end
    if (!is_in_range(RESET_VALUE, MIN_VALUE, MAX_VALUE)) begin : g_chk_reset
        $error("RESET_VALUE must lie in [MIN_VALUE, MAX_VALUE]");
    end

    localparam logic [WIDTH-1:0] MinQ   = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] MaxQ   = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] RstQ   = WIDTH'(RESET_VALUE);
    localparam logic [7:0]       RstBcd = bcd_of(RESET_VALUE);

    logic [WIDTH-1:0] q_q, q_d;
    logic [7:0]       q_bcd_q, q_bcd_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic adj_act;
    logic at_max;
    logic at_min;
    logic q_ok;
    logic load_ok;

    assign adj_act = adj_inc ^ adj_dec;
    assign at_max  = (q_q == MaxQ);
    assign at_min  = (q_q == MinQ);
    assign q_ok    = is_in_range(32'(q_q), MIN_VALUE, MAX_VALUE);
    assign load_ok = is_in_range(32'(load_value), MIN_VALUE, MAX_VALUE);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            if (load_ok) begin
                q_d = load_value;
            end else begin
                err_d = 1'b1;
            end
        end else if (adj_act) begin
            // Adjust wraps silently: no carry and no wrap pulse.
            if (!q_ok) begin
                q_d = MinQ;
            end else if (adj_inc) begin
                q_d = at_max ? MinQ : q_q + WIDTH'(1);
            end else begin
                q_d = at_min ? MaxQ : q_q - WIDTH'(1);
            end
        end else if (en_in) begin
            if (!q_ok) begin
                q_d = MinQ;
            end else if (up_down) begin
                if (at_max) begin
                    q_d    = MinQ;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (at_min) begin
                    q_d    = MaxQ;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    // Convert next-q so the BCD register lands on the same edge as q.
    bin2bcd_99 u_bin2bcd (
        .bin (7'(q_d)),
        .bcd (q_bcd_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q     <= RstQ;
            q_bcd_q <= RstBcd;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            q_bcd_q <= q_bcd_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign tc_out     = en_in & ~load & ~adj_act & (up_down ? at_max : at_min);
    assign q          = q_q;
    assign q_bcd      = q_bcd_q;
    assign wrap_pulse = wrap_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_mod_cascade_counter.sv
// Scoreboard bench: seconds->minutes cascade plus a 1..12 hours stage.
module tb_mod_cascade_counter;

    logic clk = 1'b0;
    logic reset;

    logic       s_en, s_ud, s_load, s_ai, s_ad;
    logic [5:0] s_lv;
    logic [5:0] s_q;
    logic [7:0] s_bcd;
    logic       s_tc, s_wrap, s_err;

    logic       m_ud, m_load, m_ai, m_ad;
    logic [5:0] m_lv;
    logic [5:0] m_q;
    logic [7:0] m_bcd;
    logic       m_tc, m_wrap, m_err;

    logic       h_en, h_ud, h_load, h_ai, h_ad;
    logic [3:0] h_lv;
    logic [3:0] h_q;
    logic [7:0] h_bcd;
    logic       h_tc, h_wrap, h_err;

    typedef struct {
        string    name;
        int       dut;
        logic [7:0] q;
        logic [7:0] bcd;
        logic     tc;
        logic     wrap;
        logic     err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mod_cascade_counter #(.WIDTH(6), .MIN_VALUE(0), .MAX_VALUE(59), .RESET_VALUE(0)) u_sec (
        .clk(clk), .reset(reset), .en_in(s_en), .up_down(s_ud), .load(s_load),
        .load_value(s_lv), .adj_inc(s_ai), .adj_dec(s_ad), .q(s_q), .q_bcd(s_bcd),
        .tc_out(s_tc), .wrap_pulse(s_wrap), .load_err(s_err)
    );

    mod_cascade_counter #(.WIDTH(6), .MIN_VALUE(0), .MAX_VALUE(59), .RESET_VALUE(0)) u_min (
        .clk(clk), .reset(reset), .en_in(s_tc), .up_down(m_ud), .load(m_load),
        .load_value(m_lv), .adj_inc(m_ai), .adj_dec(m_ad), .q(m_q), .q_bcd(m_bcd),
        .tc_out(m_tc), .wrap_pulse(m_wrap), .load_err(m_err)
    );

    mod_cascade_counter #(.WIDTH(4), .MIN_VALUE(1), .MAX_VALUE(12), .RESET_VALUE(1)) u_hr (
        .clk(clk), .reset(reset), .en_in(h_en), .up_down(h_ud), .load(h_load),
        .load_value(h_lv), .adj_inc(h_ai), .adj_dec(h_ad), .q(h_q), .q_bcd(h_bcd),
        .tc_out(h_tc), .wrap_pulse(h_wrap), .load_err(h_err)
    );

    // Expectations describe the outputs seen mid-cycle, under the inputs set this cycle.
    task automatic expect_out(input string name, input int dut, input logic [7:0] q,
                              input logic [7:0] bcd, input logic tc, input logic wrap,
                              input logic err);
        exp_t e;
        e.name = name; e.dut = dut; e.q = q; e.bcd = bcd;
        e.tc = tc; e.wrap = wrap; e.err = err;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: drain every expectation queued for this cycle at the falling edge.
    initial begin
        exp_t       e;
        logic [7:0] aq, abcd;
        logic       atc, awrap, aerr;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.dut)
                    0:       begin aq = 8'(s_q); abcd = s_bcd; atc = s_tc; awrap = s_wrap; aerr = s_err; end
                    1:       begin aq = 8'(m_q); abcd = m_bcd; atc = m_tc; awrap = m_wrap; aerr = m_err; end
                    default: begin aq = 8'(h_q); abcd = h_bcd; atc = h_tc; awrap = h_wrap; aerr = h_err; end
                endcase
                n_vec++;
                if ({aq, abcd, atc, awrap, aerr} !== {e.q, e.bcd, e.tc, e.wrap, e.err}) begin
                    n_bad++;
                    $display("FAIL %s: got q=%0d bcd=%h tc=%b wrap=%b err=%b, want q=%0d bcd=%h tc=%b wrap=%b err=%b",
                             e.name, aq, abcd, atc, awrap, aerr, e.q, e.bcd, e.tc, e.wrap, e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        s_en = 1'b1; s_ud = 1'b1; s_load = 1'b0; s_lv = '0; s_ai = 1'b0; s_ad = 1'b0;
        m_ud = 1'b1; m_load = 1'b0; m_lv = '0; m_ai = 1'b0; m_ad = 1'b0;
        h_en = 1'b0; h_ud = 1'b1; h_load = 1'b0; h_lv = '0; h_ai = 1'b0; h_ad = 1'b0;
        tick();

        // Reset held with enable active
        expect_out("rst_sec", 0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        expect_out("rst_min", 1, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        expect_out("rst_hr",  2, 8'd1, 8'h01, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("rst_hold", 0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        expect_out("rst_release", 0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        s_en = 1'b0;
        expect_out("count_first", 0, 8'd1, 8'h01, 1'b0, 1'b0, 1'b0);
        tick();

        // Up wrap at 59
        s_load = 1'b1; s_lv = 6'd58;
        tick();
        s_load = 1'b0; s_en = 1'b1;
        expect_out("load58", 0, 8'd58, 8'h58, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("tc_at59", 0, 8'd59, 8'h59, 1'b1, 1'b0, 1'b0);
        expect_out("min_en_tc", 1, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        s_en = 1'b0;
        expect_out("up_wrap", 0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        expect_out("min_carry", 1, 8'd1, 8'h01, 1'b0, 1'b0, 1'b0);
        tick();

        // Load range check
        s_load = 1'b1; s_lv = 6'd60;
        expect_out("wrap_one_cycle", 0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        s_lv = 6'd37;
        expect_out("load_bad", 0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        s_load = 1'b0;
        expect_out("load_ok", 0, 8'd37, 8'h37, 1'b0, 1'b0, 1'b0);
        tick();

        // Adjust versus carry
        s_load = 1'b1; s_lv = 6'd59;
        tick();
        s_load = 1'b0; s_en = 1'b1; s_ai = 1'b1;
        expect_out("adj_blocks_tc", 0, 8'd59, 8'h59, 1'b0, 1'b0, 1'b0);
        expect_out("adj_min_idle", 1, 8'd1, 8'h01, 1'b0, 1'b0, 1'b0);
        tick();
        s_en = 1'b0; s_ad = 1'b1;
        expect_out("adj_inc_wrap", 0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        s_ai = 1'b0;
        expect_out("adj_both_hold", 0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        s_ad = 1'b0;
        expect_out("adj_dec_wrap", 0, 8'd59, 8'h59, 1'b0, 1'b0, 1'b0);

        // Hours 1..12 down wrap, then up wrap
        h_en = 1'b1; h_ud = 1'b0;
        expect_out("hr_tc_down", 2, 8'd1, 8'h01, 1'b1, 1'b0, 1'b0);
        tick();
        h_ud = 1'b1;
        expect_out("hr_down_wrap", 2, 8'd12, 8'h12, 1'b1, 1'b1, 1'b0);
        tick();
        h_en = 1'b0;
        expect_out("hr_up_wrap", 2, 8'd1, 8'h01, 1'b0, 1'b1, 1'b0);
        tick();

        // Cascade 59:59 -> 00:00
        m_load = 1'b1; m_lv = 6'd59;
        tick();
        m_load = 1'b0; s_en = 1'b1;
        expect_out("casc_sec_tc", 0, 8'd59, 8'h59, 1'b1, 1'b0, 1'b0);
        expect_out("casc_min_tc", 1, 8'd59, 8'h59, 1'b1, 1'b0, 1'b0);
        tick();
        s_en = 1'b0;
        expect_out("casc_sec_wrap", 0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        expect_out("casc_min_wrap", 1, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        s_load = 1'b1; s_lv = 6'd23;
        expect_out("casc_min_1cyc", 1, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        s_load = 1'b0;
        expect_out("load23", 0, 8'd23, 8'h23, 1'b0, 1'b0, 1'b0);
        tick();

        // Asynchronous reset between edges
        reset = 1'b0;
        expect_out("async_rst", 0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        tick();

        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
